// File: rtl/mandelbrot_pkg.sv
// Shared constants for the Mandelbrot iteration engine:
// mode codes, FSM state encoding and the escape threshold.
package mandelbrot_pkg;

  localparam logic [1:0] MODE_MANDEL = 2'd0;
  localparam logic [1:0] MODE_JULIA  = 2'd1;
  localparam logic [1:0] MODE_SHIP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    UPD  = 2'd2,
    DONE = 2'd3
  } state_t;

  // 4.0 in the 4.(2W-4) product format
  function automatic logic [127:0] FOUR(input int unsigned w);
    return 128'd4 << (2 * w - 4);
  endfunction

endpackage

// File: rtl/mandelbrot_step_dp.sv
// Combinational update step: next z from registered products,
// plus the magnitude-escape and overflow flags.
module mandelbrot_step_dp
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [2*WIDTH-1:0] i_m1,
  input  logic signed [2*WIDTH-1:0] i_m2,
  input  logic signed [2*WIDTH-1:0] i_m3,
  input  logic signed [WIDTH-1:0]   i_cr,
  input  logic signed [WIDTH-1:0]   i_ci,
  output logic signed [WIDTH-1:0]   o_nzr,
  output logic signed [WIDTH-1:0]   o_nzi,
  output logic                      o_size,
  output logic                      o_ovf
);

  localparam logic [2*WIDTH:0] L_FOUR =
    (2*WIDTH+1)'(FOUR(WIDTH));

  logic [2*WIDTH:0]        w_sum;
  logic signed [2*WIDTH:0] w_diff;
  logic signed [2*WIDTH:0] w_m3e;
  logic signed [WIDTH+2:0] w_nzr;
  logic signed [WIDTH+3:0] w_nzi;

  assign w_sum  = {1'b0, i_m1} + {1'b0, i_m2};
  assign w_diff = {i_m1[2*WIDTH-1], i_m1}
                - {i_m2[2*WIDTH-1], i_m2};
  assign w_m3e  = {i_m3[2*WIDTH-1], i_m3};

  // shift by W-3 on zr*zi yields 2*zr*zi
  assign w_nzr = (WIDTH+3)'(w_diff >>> (WIDTH-2))
               + {{3{i_cr[WIDTH-1]}}, i_cr};
  assign w_nzi = (WIDTH+4)'(w_m3e >>> (WIDTH-3))
               + {{4{i_ci[WIDTH-1]}}, i_ci};

  assign o_size = w_sum > L_FOUR;
  assign o_ovf  =
    !((&w_nzr[WIDTH+2:WIDTH-1]) || !(|w_nzr[WIDTH+2:WIDTH-1])) ||
    !((&w_nzi[WIDTH+3:WIDTH-1]) || !(|w_nzi[WIDTH+3:WIDTH-1]));

  assign o_nzr = w_nzr[WIDTH-1:0];
  assign o_nzi = w_nzi[WIDTH-1:0];

endmodule

// File: rtl/mandelbrot_iter_engine.sv
// Per-pixel z = z^2 + c iteration engine with valid/ready I/O.
// Define BURNING_SHIP_EN to enable mode 2 (abs of z before squaring).
module mandelbrot_iter_engine
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ITER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [WIDTH-1:0]      in_pr,
  input  logic [WIDTH-1:0]      in_pi,
  input  logic [WIDTH-1:0]      julia_cr,
  input  logic [WIDTH-1:0]      julia_ci,
  input  logic [ITER_WIDTH-1:0] max_iter,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ITER_WIDTH-1:0] out_iter,
  output logic                  out_escaped,
  output logic                  busy
);

  state_t r_state, w_next;

  logic signed [WIDTH-1:0]   r_zr, r_zi, r_cr, r_ci;
  logic signed [2*WIDTH-1:0] r_m1, r_m2, r_m3;
  logic [ITER_WIDTH-1:0]     r_iter, r_max, r_out_iter;
  logic                      r_out_esc;

  logic signed [WIDTH-1:0] w_ar, w_ai, w_nzr, w_nzi;
  logic                    w_size, w_ovf, w_last;
  logic [ITER_WIDTH-1:0]   w_iter_inc;

`ifdef BURNING_SHIP_EN
  logic r_ship;

  function automatic logic signed [WIDTH-1:0] f_abs(
    input logic signed [WIDTH-1:0] a
  );
    if (a == {1'b1, {(WIDTH-1){1'b0}}})
      return {1'b0, {(WIDTH-1){1'b1}}};
    return a[WIDTH-1] ? -a : a;
  endfunction

  assign w_ar = r_ship ? f_abs(r_zr) : r_zr;
  assign w_ai = r_ship ? f_abs(r_zi) : r_zi;
`else
  assign w_ar = r_zr;
  assign w_ai = r_zi;
`endif

  mandelbrot_step_dp #(.WIDTH(WIDTH)) u_dp (
    .i_m1   (r_m1),
    .i_m2   (r_m2),
    .i_m3   (r_m3),
    .i_cr   (r_cr),
    .i_ci   (r_ci),
    .o_nzr  (w_nzr),
    .o_nzi  (w_nzi),
    .o_size (w_size),
    .o_ovf  (w_ovf)
  );

  assign w_iter_inc = r_iter + ITER_WIDTH'(1);
  assign w_last     = (w_iter_inc == r_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (in_valid)
          w_next = (max_iter == '0) ? DONE : MUL;
      MUL: w_next = UPD;
      UPD:
        w_next = (w_size || w_ovf || w_last) ? DONE : MUL;
      DONE:
        if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zr       <= '0;
      r_zi       <= '0;
      r_cr       <= '0;
      r_ci       <= '0;
      r_m1       <= '0;
      r_m2       <= '0;
      r_m3       <= '0;
      r_iter     <= '0;
      r_max      <= '0;
      r_out_iter <= '0;
      r_out_esc  <= 1'b0;
`ifdef BURNING_SHIP_EN
      r_ship     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_iter <= '0;
          r_max  <= max_iter;
          if (in_mode == MODE_JULIA) begin
            r_zr <= in_pr;
            r_zi <= in_pi;
            r_cr <= julia_cr;
            r_ci <= julia_ci;
          end else begin
            r_zr <= '0;
            r_zi <= '0;
            r_cr <= in_pr;
            r_ci <= in_pi;
          end
`ifdef BURNING_SHIP_EN
          r_ship <= (in_mode == MODE_SHIP);
`endif
          if (max_iter == '0) begin
            r_out_iter <= '0;
            r_out_esc  <= 1'b0;
          end
        end
        MUL: begin
          r_m1 <= (2*WIDTH)'(w_ar) * (2*WIDTH)'(w_ar);
          r_m2 <= (2*WIDTH)'(w_ai) * (2*WIDTH)'(w_ai);
          r_m3 <= (2*WIDTH)'(w_ar) * (2*WIDTH)'(w_ai);
        end
        UPD:
          if (w_size || w_ovf) begin
            r_out_iter <= r_iter;
            r_out_esc  <= 1'b1;
          end else if (w_last) begin
            r_out_iter <= r_max;
            r_out_esc  <= 1'b0;
          end else begin
            r_zr   <= w_nzr;
            r_zi   <= w_nzi;
            r_iter <= w_iter_inc;
          end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign out_iter    = r_out_iter;
  assign out_escaped = r_out_esc;

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Directed + random bench for mandelbrot_iter_engine (WIDTH=8),
// checked against an integer-arithmetic escape-time model.
module tb_mandelbrot_iter_engine;

  localparam int W  = 8;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_mode = '0;
  logic [W-1:0]  in_pr = '0, in_pi = '0;
  logic [W-1:0]  julia_cr = '0, julia_ci = '0;
  logic [IW-1:0] max_iter = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_iter;
  logic          out_escaped;
  logic          busy;

  int total = 0;
  int bad   = 0;

  mandelbrot_iter_engine #(.WIDTH(W), .ITER_WIDTH(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_pr       (in_pr),
    .in_pi       (in_pi),
    .julia_cr    (julia_cr),
    .julia_ci    (julia_ci),
    .max_iter    (max_iter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int sabs(input int v);
    if (v == -(1 << (W-1))) return (1 << (W-1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  // Escape-time reference using real-valued scale 2^(W-2)
  function automatic void model(
    input int mode, input int pr, input int pi,
    input int jr, input int ji, input int mx,
    output int it, output int esc, output int k);
    int zr, zi, cr, ci, ar, ai, m1, m2, m3, nr, ni;
    bit ship;
    ship = 1'b0;
`ifdef BURNING_SHIP_EN
    ship = (mode == 2);
`endif
    if (mode == 1) begin
      zr = pr; zi = pi; cr = jr; ci = ji;
    end else begin
      zr = 0; zi = 0; cr = pr; ci = pi;
    end
    it = 0; esc = 0; k = 0;
    if (mx == 0) return;
    for (int s = 0; s < 300; s++) begin
      ar = ship ? sabs(zr) : zr;
      ai = ship ? sabs(zi) : zi;
      k++;
      m1 = ar * ar;
      m2 = ai * ai;
      m3 = ar * ai;
      nr = ((m1 - m2) >>> (W-2)) + cr;
      ni = ((2 * m3) >>> (W-2)) + ci;
      if (m1 + m2 > (4 << (2*W-4)) ||
          nr < -(1 << (W-1)) || nr >= (1 << (W-1)) ||
          ni < -(1 << (W-1)) || ni >= (1 << (W-1))) begin
        esc = 1;
        return;
      end
      if (it + 1 == mx) begin
        it = mx;
        return;
      end
      zr = nr; zi = ni; it++;
    end
  endfunction

  task automatic run_pixel(input string tag, input int mode,
    input logic [W-1:0] pr, input logic [W-1:0] pi,
    input logic [W-1:0] jr, input logic [W-1:0] ji,
    input int mx, input int bp);
    int eit, eesc, ek, n;
    model(mode, int'($signed(pr)), int'($signed(pi)),
          int'($signed(jr)), int'($signed(ji)), mx, eit, eesc, ek);
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    in_mode = 2'(mode); in_pr = pr; in_pi = pi;
    julia_cr = jr; julia_ci = ji; max_iter = IW'(mx);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode = 2'($urandom); in_pr = W'($urandom); in_pi = W'($urandom);
    julia_cr = W'($urandom); julia_ci = W'($urandom);
    max_iter = IW'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 1000);
    chk({tag, ".latency"}, 32'(n), 32'(2 * ek + 1));
    chk({tag, ".iter"}, 32'(out_iter), 32'(eit));
    chk({tag, ".esc"}, 32'(out_escaped), 32'(eesc));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({tag, ".bp_valid"}, 32'(out_valid), 1);
      chk({tag, ".bp_ready"}, 32'(in_ready), 0);
      chk({tag, ".bp_iter"}, 32'(out_iter), 32'(eit));
      chk({tag, ".bp_esc"}, 32'(out_escaped), 32'(eesc));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".post_valid"}, 32'(out_valid), 0);
    chk({tag, ".post_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    #12;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_iter", 32'(out_iter), 0);
    chk("rst.out_esc", 32'(out_escaped), 0);
    chk("rst.busy", 32'(busy), 0);
    rst = 1'b0;

    run_pixel("origin",  0, 8'h00, 8'h00, 8'h00, 8'h00, 16, 0);
    run_pixel("c1p5",    0, 8'h60, 8'h60, 8'h00, 8'h00, 16, 0);
    run_pixel("cm2",     0, 8'h80, 8'h00, 8'h00, 8'h00, 16, 0);
    run_pixel("julia1",  1, 8'h40, 8'h00, 8'h00, 8'h00, 5, 0);
    run_pixel("max0",    1, 8'h40, 8'h00, 8'h00, 8'h00, 0, 0);
    run_pixel("bp",      0, 8'h60, 8'h60, 8'h00, 8'h00, 16, 10);
    run_pixel("mode3",   3, 8'h10, 8'hF0, 8'h20, 8'h20, 12, 0);
    run_pixel("ship",    2, 8'h00, 8'hC0, 8'h00, 8'h00, 4, 0);

    @(negedge clk);
    in_mode = 2'd0; in_pr = 8'h00; in_pi = 8'h00;
    max_iter = 8'd16; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort.busy_mul", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort.out_valid", 32'(out_valid), 0);
    chk("abort.in_ready", 32'(in_ready), 1);
    chk("abort.busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    run_pixel("rerun",   0, 8'h60, 8'h60, 8'h00, 8'h00, 16, 0);

    for (int r = 0; r < 40; r++) begin
      run_pixel("rand", int'($urandom_range(0, 3)),
                W'($urandom), W'($urandom),
                W'($urandom), W'($urandom),
                int'($urandom_range(0, 24)),
                int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
